// File: rtl/intcode_d2_sequencer.sv
// Day 2 Intcode instruction sequencer: fetches add/mul/halt instructions from a
// one-cycle-latency program memory, executes them and writes results back.
// Read data is consumed in the cycle it arrives, so the strobes, address and
// write data are decoded from the current state together with the returned word.
module intcode_d2_sequencer #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [6:0]            mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  halted,
  output logic                  error,
  output logic [6:0]            ip,
  output logic [15:0]           retired
);

  typedef enum logic [3:0] {
    StIdle,
    StF0,
    StF1,
    StF2,
    StF3,
    StF4,
    StF5,
    StEx,
    StHalt,
    StError
  } state_e;

  localparam logic [DATA_WIDTH-1:0] OpAdd  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] OpMul  = DATA_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] OpHalt = DATA_WIDTH'(99);

  state_e                state_q;
  logic [6:0]            ip_q;
  logic [15:0]           retired_q;
  logic                  mul_q;
  logic [6:0]            ptr_a_q;
  logic [6:0]            ptr_b_q;
  logic [6:0]            dst_q;
  logic [DATA_WIDTH-1:0] a_q;

  logic                  op_arith;
  logic                  ptr_ok;
  logic [DATA_WIDTH-1:0] result;

  // Decode of the word currently arriving from memory.
  always_comb begin
    op_arith = (mem_rdata == OpAdd) || (mem_rdata == OpMul);
    // A word is a legal pointer only if nothing above bit 6 is set.
    ptr_ok   = (mem_rdata >> 7) == '0;
    result   = mul_q ? (a_q * mem_rdata) : (a_q + mem_rdata);
  end

  // Memory strobes: a read is only issued when the word just captured is legal,
  // so a faulting fetch produces no further traffic.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 7'd0;
    mem_wdata = '0;
    case (state_q)
      StF0: begin
        mem_rd   = 1'b1;
        mem_addr = ip_q;
      end
      StF1: begin
        if (op_arith) begin
          mem_rd   = 1'b1;
          mem_addr = ip_q + 7'd1;
        end
      end
      StF2: begin
        if (ptr_ok) begin
          mem_rd   = 1'b1;
          mem_addr = ip_q + 7'd2;
        end
      end
      StF3: begin
        if (ptr_ok) begin
          mem_rd   = 1'b1;
          mem_addr = ip_q + 7'd3;
        end
      end
      StF4: begin
        if (ptr_ok) begin
          mem_rd   = 1'b1;
          mem_addr = ptr_a_q;
        end
      end
      StF5: begin
        mem_rd   = 1'b1;
        mem_addr = ptr_b_q;
      end
      StEx: begin
        mem_wr    = 1'b1;
        mem_addr  = dst_q;
        mem_wdata = result;
      end
      default: ;
    endcase
  end

  // Status flags follow the state register directly.
  always_comb begin
    busy    = !(state_q inside {StIdle, StHalt, StError});
    halted  = (state_q == StHalt);
    error   = (state_q == StError);
    ip      = ip_q;
    retired = retired_q;
  end

  // Sequencer FSM with operand capture and instruction bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ip_q      <= 7'd0;
      retired_q <= 16'd0;
      mul_q     <= 1'b0;
      ptr_a_q   <= 7'd0;
      ptr_b_q   <= 7'd0;
      dst_q     <= 7'd0;
      a_q       <= '0;
    end else begin
      case (state_q)
        StIdle, StHalt, StError: begin
          if (start) begin
            ip_q      <= 7'd0;
            retired_q <= 16'd0;
            state_q   <= StF0;
          end
        end
        StF0: state_q <= StF1;
        StF1: begin
          if (mem_rdata == OpHalt) begin
            state_q <= StHalt;
          end else if (op_arith) begin
            mul_q   <= (mem_rdata == OpMul);
            state_q <= StF2;
          end else begin
            state_q <= StError;
          end
        end
        StF2: begin
          ptr_a_q <= mem_rdata[6:0];
          state_q <= ptr_ok ? StF3 : StError;
        end
        StF3: begin
          ptr_b_q <= mem_rdata[6:0];
          state_q <= ptr_ok ? StF4 : StError;
        end
        StF4: begin
          dst_q   <= mem_rdata[6:0];
          state_q <= ptr_ok ? StF5 : StError;
        end
        StF5: begin
          a_q     <= mem_rdata;
          state_q <= StEx;
        end
        StEx: begin
          retired_q <= retired_q + 16'd1;
          // ip+4 would leave the 7-bit address space; stop at the last instruction.
          if (ip_q <= 7'd123) begin
            ip_q    <= ip_q + 7'd4;
            state_q <= StF0;
          end else begin
            state_q <= StError;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
